// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: A/D opcodes, bridge FSM states and the
// command legality rule used by the initiator bridge.
package tl_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITH       = 3'd2,
    A_LOGICAL     = 3'd3,
    A_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_A_REQ   = 2'd1,
    ST_D_WAIT  = 2'd2,
    ST_ERR_RSP = 2'd3
  } bridge_state_e;

  // Opcode/size/alignment legality; bursts beyond a word only need word alignment.
  function automatic logic cmd_is_legal(input logic [2:0] opcode,
                                        input logic [3:0] size,
                                        input logic [1:0] addr_lo,
                                        input logic [3:0] max_size);
    logic size_ok;
    logic align_ok;
    size_ok  = 1'b0;
    align_ok = 1'b0;
    case (opcode)
      A_GET:                                     size_ok = (size <= max_size);
      A_PUT_FULL, A_PUT_PARTIAL, A_ARITH, A_LOGICAL: size_ok = (size <= 4'd2);
      default:                                   size_ok = 1'b0;
    endcase
    case (size)
      4'd0:    align_ok = 1'b1;
      4'd1:    align_ok = ~addr_lo[0];
      default: align_ok = (addr_lo == 2'b00);
    endcase
    return size_ok & align_ok;
  endfunction

endpackage

// File: rtl/tl_mask_gen.sv
// Derives the 32-bit-lane byte mask implied by a TL size and address offset.
module tl_mask_gen (
  input  logic [3:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] mask_o
);

  // Sub-word accesses enable only the addressed lanes.
  always_comb begin
    mask_o = 4'h0;
    case (size_i)
      4'd0:    mask_o = 4'b0001 << addr_lo_i;
      4'd1:    mask_o = 4'b0011 << addr_lo_i;
      default: mask_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/tl_ul_master_bridge.sv
// Single-outstanding TileLink-UL initiator: one command becomes one A request,
// each D beat is returned through a one-entry registered response buffer.
module tl_ul_master_bridge
  import tl_pkg::*;
#(
  parameter int TL_AW     = 32,
  parameter int TL_RS     = 4,
  parameter int SOURCE_ID = 0,
  parameter int MAX_SIZE  = 6
) (
  input  logic             tlm_clock_i,
  input  logic             tlm_reset_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [2:0]       cmd_param,
  input  logic [3:0]       cmd_size,
  input  logic [TL_AW-1:0] cmd_address,
  input  logic [3:0]       cmd_mask,
  input  logic [31:0]      cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_error,
  output logic             rsp_last,
  output logic [2:0]       tl_a_opcode,
  output logic [2:0]       tl_a_param,
  output logic [3:0]       tl_a_size,
  output logic [TL_RS-1:0] tl_a_source,
  output logic [TL_AW-1:0] tl_a_address,
  output logic [3:0]       tl_a_mask,
  output logic [31:0]      tl_a_data,
  output logic             tl_a_corrupt,
  output logic             tl_a_valid,
  input  logic             tl_a_ready,
  input  logic [2:0]       tl_d_opcode,
  input  logic [1:0]       tl_d_param,
  input  logic [3:0]       tl_d_size,
  input  logic [TL_RS-1:0] tl_d_source,
  input  logic             tl_d_denied,
  input  logic [31:0]      tl_d_data,
  input  logic             tl_d_corrupt,
  input  logic             tl_d_valid,
  output logic             tl_d_ready,
  output logic             proto_err_o
);

  localparam int               CNT_W    = (MAX_SIZE > 2) ? (MAX_SIZE - 2) : 1;
  localparam logic [TL_RS-1:0] SRC_ID   = TL_RS'(SOURCE_ID);
  localparam logic [3:0]       MAX_SZ   = 4'(MAX_SIZE);

  bridge_state_e     state_q, state_d;
  logic [2:0]        a_opcode_q, a_opcode_d;
  logic [2:0]        a_param_q, a_param_d;
  logic [3:0]        a_size_q, a_size_d;
  logic [TL_AW-1:0]  a_address_q, a_address_d;
  logic [3:0]        a_mask_q, a_mask_d;
  logic [31:0]       a_data_q, a_data_d;
  logic              a_valid_q, a_valid_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic              rsp_last_q, rsp_last_d;
  logic              proto_err_q, proto_err_d;

  logic [3:0]        derived_mask_s;
  logic              buf_free_s;
  logic              cmd_fire_s;
  logic              d_fire_s;
  logic              unused_d_s;

  tl_mask_gen u_mask_gen (
    .size_i    (cmd_size),
    .addr_lo_i (cmd_address[1:0]),
    .mask_o    (derived_mask_s)
  );

  assign unused_d_s = ^{tl_d_param, tl_d_size};

  // Handshake readiness depends only on state and the response buffer, never on the peer's valid.
  always_comb begin
    buf_free_s = ~rsp_valid_q | rsp_ready;
    cmd_ready  = tlm_reset_ni & (state_q == ST_IDLE) & buf_free_s;
    if (state_q == ST_D_WAIT) begin
      tl_d_ready = tlm_reset_ni & buf_free_s;
    end else begin
      tl_d_ready = tlm_reset_ni;
    end
    cmd_fire_s = cmd_valid & cmd_ready;
    d_fire_s   = tl_d_valid & tl_d_ready;
  end

  // Next-state, A-channel field capture, beat counting and response loading.
  always_comb begin
    state_d     = state_q;
    a_opcode_d  = a_opcode_q;
    a_param_d   = a_param_q;
    a_size_d    = a_size_q;
    a_address_d = a_address_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
    a_valid_d   = a_valid_q;
    beat_cnt_d  = beat_cnt_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    rsp_last_d  = rsp_last_q;
    proto_err_d = proto_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          if (cmd_is_legal(cmd_opcode, cmd_size, cmd_address[1:0], MAX_SZ)) begin
            a_opcode_d  = cmd_opcode;
            a_param_d   = cmd_param;
            a_size_d    = cmd_size;
            a_address_d = cmd_address;
            a_mask_d    = (cmd_opcode == A_PUT_PARTIAL) ? (cmd_mask & derived_mask_s)
                                                        : derived_mask_s;
            a_data_d    = cmd_data;
            a_valid_d   = 1'b1;
            state_d     = ST_A_REQ;
          end else begin
            state_d     = ST_ERR_RSP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_A_REQ: begin
        if (tl_a_ready) begin
          a_valid_d = 1'b0;
          // Beats minus one = 2^(size-2)-1: bit i is set when size > i+2.
          for (int i = 0; i < CNT_W; i++) begin
            beat_cnt_d[i] = (32'(a_size_q) > (32'(i) + 32'd2));
          end
          state_d = ST_D_WAIT;
        end else begin
          state_d = ST_A_REQ;
        end
      end
      ST_D_WAIT: begin
        if (d_fire_s) begin
          if (tl_d_source == SRC_ID) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = (tl_d_opcode == D_ACCESS_ACK_DATA) ? tl_d_data : 32'h0;
            rsp_error_d = tl_d_denied | tl_d_corrupt;
            rsp_last_d  = (beat_cnt_q == '0);
            if (beat_cnt_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              beat_cnt_d = beat_cnt_q - 1'b1;
            end
          end else begin
            proto_err_d = 1'b1;
          end
        end else begin
          state_d = ST_D_WAIT;
        end
      end
      ST_ERR_RSP: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = 32'h0;
        rsp_error_d = 1'b1;
        rsp_last_d  = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (d_fire_s && (state_q != ST_D_WAIT)) begin
      proto_err_d = 1'b1;
    end else begin
      proto_err_d = proto_err_d;
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge tlm_clock_i or negedge tlm_reset_ni) begin
    if (!tlm_reset_ni) begin
      state_q     <= ST_IDLE;
      a_opcode_q  <= 3'd0;
      a_param_q   <= 3'd0;
      a_size_q    <= 4'd0;
      a_address_q <= '0;
      a_mask_q    <= 4'h0;
      a_data_q    <= 32'h0;
      a_valid_q   <= 1'b0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_error_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_opcode_q  <= a_opcode_d;
      a_param_q   <= a_param_d;
      a_size_q    <= a_size_d;
      a_address_q <= a_address_d;
      a_mask_q    <= a_mask_d;
      a_data_q    <= a_data_d;
      a_valid_q   <= a_valid_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      rsp_last_q  <= rsp_last_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign tl_a_opcode  = a_opcode_q;
  assign tl_a_param   = a_param_q;
  assign tl_a_size    = a_size_q;
  assign tl_a_source  = SRC_ID;
  assign tl_a_address = a_address_q;
  assign tl_a_mask    = a_mask_q;
  assign tl_a_data    = a_data_q;
  assign tl_a_corrupt = 1'b0;
  assign tl_a_valid   = a_valid_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_error    = rsp_error_q;
  assign rsp_last     = rsp_last_q;
  assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_tl_ul_master_bridge.sv
// Self-checking bench: directed scenarios plus random commands, compared against
// a queue-based response model derived from the TileLink-UL bridge rules.
module tb_tl_ul_master_bridge;

  localparam int TL_AW     = 32;
  localparam int TL_RS     = 4;
  localparam int SOURCE_ID = 0;
  localparam int MAX_SIZE  = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_opcode, cmd_param;
  logic [3:0]       cmd_size, cmd_mask;
  logic [31:0]      cmd_address, cmd_data;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [31:0]      rsp_data;
  logic             rsp_error, rsp_last;
  logic [2:0]       tl_a_opcode, tl_a_param;
  logic [3:0]       tl_a_size, tl_a_mask;
  logic [TL_RS-1:0] tl_a_source;
  logic [31:0]      tl_a_address, tl_a_data;
  logic             tl_a_corrupt, tl_a_valid, tl_a_ready;
  logic [2:0]       tl_d_opcode;
  logic [1:0]       tl_d_param;
  logic [3:0]       tl_d_size;
  logic [TL_RS-1:0] tl_d_source;
  logic             tl_d_denied, tl_d_corrupt, tl_d_valid, tl_d_ready;
  logic [31:0]      tl_d_data;
  logic             proto_err_o;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        last;
  } rsp_t;

  rsp_t     exp_q[$];
  int       checks = 0;
  int       errors = 0;
  int       rdy_mode = 0;
  logic     in_d = 1'b0;
  logic     exp_proto = 1'b0;

  always #5 clk = ~clk;

  tl_ul_master_bridge #(
    .TL_AW(TL_AW), .TL_RS(TL_RS), .SOURCE_ID(SOURCE_ID), .MAX_SIZE(MAX_SIZE)
  ) dut (
    .tlm_clock_i(clk), .tlm_reset_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_param(cmd_param), .cmd_size(cmd_size), .cmd_address(cmd_address),
    .cmd_mask(cmd_mask), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_last(rsp_last),
    .tl_a_opcode(tl_a_opcode), .tl_a_param(tl_a_param), .tl_a_size(tl_a_size),
    .tl_a_source(tl_a_source), .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask),
    .tl_a_data(tl_a_data), .tl_a_corrupt(tl_a_corrupt), .tl_a_valid(tl_a_valid),
    .tl_a_ready(tl_a_ready),
    .tl_d_opcode(tl_d_opcode), .tl_d_param(tl_d_param), .tl_d_size(tl_d_size),
    .tl_d_source(tl_d_source), .tl_d_denied(tl_d_denied), .tl_d_data(tl_d_data),
    .tl_d_corrupt(tl_d_corrupt), .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready),
    .proto_err_o(proto_err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rules expressed arithmetically.
  function automatic logic legal_m(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr);
    int align;
    align = 1 << ((sz < 4'd2) ? int'(sz) : 2);
    if (op > 3'd4) return 1'b0;
    if ((op == 3'd4) ? (int'(sz) > MAX_SIZE) : (sz > 4'd2)) return 1'b0;
    return (int'(addr % 32'(align)) == 0);
  endfunction

  function automatic logic [3:0] mask_m(input logic [2:0] op, input logic [3:0] sz,
                                        input logic [31:0] addr, input logic [3:0] cm);
    int lanes, first;
    logic [3:0] m;
    lanes = (sz >= 4'd2) ? 4 : (1 << sz);
    first = int'(addr % 32'd4);
    m = 4'h0;
    for (int b = 0; b < 4; b++) if (b >= first && b < first + lanes) m[b] = 1'b1;
    return (op == 3'd1) ? (m & cm) : m;
  endfunction

  // Response consumer: 0 always ready, 1 toggling, 2 stalled.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1:       rsp_ready = ~rsp_ready;
      2:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  // Scoreboard of consumed responses and D-channel backpressure rule.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(e.data));
          check("rsp_error", 64'(rsp_error), 64'(e.err));
          check("rsp_last", 64'(rsp_last), 64'(e.last));
        end
      end
      if (in_d) check("d_ready_backpressure", 64'(tl_d_ready), 64'(!rsp_valid || rsp_ready));
    end
  end

  task automatic issue_cmd(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                           input logic [31:0] addr, input logic [3:0] cm, input logic [31:0] wd);
    int n;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_param = prm; cmd_size = sz;
    cmd_address = addr; cmd_mask = cm; cmd_data = wd;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic a_phase(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                         input logic [31:0] addr, input logic [3:0] em, input logic [31:0] wd,
                         input int a_delay);
    check("a_valid_latency", 64'(tl_a_valid), 64'd1);
    for (int i = 0; i <= a_delay; i++) begin
      check("a_valid_held", 64'(tl_a_valid), 64'd1);
      check("a_opcode", 64'(tl_a_opcode), 64'(op));
      check("a_param", 64'(tl_a_param), 64'(prm));
      check("a_size", 64'(tl_a_size), 64'(sz));
      check("a_address", 64'(tl_a_address), 64'(addr));
      check("a_mask", 64'(tl_a_mask), 64'(em));
      check("a_data", 64'(tl_a_data), 64'(wd));
      check("a_source", 64'(tl_a_source), 64'(SOURCE_ID));
      check("a_corrupt", 64'(tl_a_corrupt), 64'd0);
      if (i < a_delay) @(negedge clk);
    end
    tl_a_ready = 1'b1;
    @(negedge clk);
    tl_a_ready = 1'b0;
    check("a_valid_drop", 64'(tl_a_valid), 64'd0);
    in_d = 1'b1;
  endtask

  task automatic d_beat(input logic [2:0] dop, input logic [31:0] dd, input logic [3:0] src,
                        input logic den, input logic last, input logic expect_rsp);
    int n;
    rsp_t e;
    tl_d_valid = 1'b1; tl_d_opcode = dop; tl_d_data = dd; tl_d_source = src;
    tl_d_denied = den; tl_d_corrupt = 1'b0; tl_d_param = 2'd0; tl_d_size = 4'd2;
    n = 0;
    while (!tl_d_ready && n < 100) begin @(negedge clk); n++; end
    check("d_ready_timeout", 64'(tl_d_ready), 64'd1);
    if (last) in_d = 1'b0;
    if (expect_rsp) begin
      e.data = (dop == 3'd1) ? dd : 32'd0;
      e.err  = den;
      e.last = last;
      exp_q.push_back(e);
    end
    @(negedge clk);
    tl_d_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin @(negedge clk); n++; end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    check("proto_err", 64'(proto_err_o), 64'(exp_proto));
  endtask

  // dmode: 0 random data/denied, 1 sequential 1..N, 2 fixed dfix.
  task automatic do_txn(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                        input logic [31:0] addr, input logic [3:0] cm, input logic [31:0] wd,
                        input int a_delay, input logic bad_src, input int dmode,
                        input logic [31:0] dfix);
    int   nbeats;
    logic [31:0] d;
    logic den;
    rsp_t e;
    issue_cmd(op, prm, sz, addr, cm, wd);
    if (!legal_m(op, sz, addr)) begin
      e.data = 32'd0; e.err = 1'b1; e.last = 1'b1;
      exp_q.push_back(e);
      check("illegal_no_a_valid", 64'(tl_a_valid), 64'd0);
      @(negedge clk);
      check("illegal_no_a_valid2", 64'(tl_a_valid), 64'd0);
      check("illegal_rsp_valid", 64'(rsp_valid), 64'd1);
    end else begin
      a_phase(op, prm, sz, addr, mask_m(op, sz, addr, cm), wd, a_delay);
      nbeats = (sz > 4'd2) ? (1 << (sz - 4'd2)) : 1;
      if (bad_src) begin
        d_beat(3'd1, 32'hBAD0BAD0, 4'(SOURCE_ID + 1), 1'b0, 1'b0, 1'b0);
        exp_proto = 1'b1;
        check("proto_err_set", 64'(proto_err_o), 64'd1);
        check("bad_src_no_rsp", 64'(rsp_valid), 64'd0);
      end
      for (int b = 0; b < nbeats; b++) begin
        d   = (dmode == 1) ? 32'(b + 1) : ((dmode == 2) ? dfix : $urandom);
        den = (dmode == 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
        d_beat((op == 3'd4) ? 3'd1 : 3'd0, d, 4'(SOURCE_ID), den, (b == nbeats - 1), 1'b1);
      end
    end
    wait_drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [3:0]  sz;
    logic [31:0] addr;
    cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_param = 3'd0; cmd_size = 4'd0;
    cmd_address = 32'd0; cmd_mask = 4'd0; cmd_data = 32'd0; tl_a_ready = 1'b0;
    tl_d_valid = 1'b0; tl_d_opcode = 3'd0; tl_d_param = 2'd0; tl_d_size = 4'd0;
    tl_d_source = '0; tl_d_denied = 1'b0; tl_d_data = 32'd0; tl_d_corrupt = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check("reset_a_valid", 64'(tl_a_valid), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_d_ready", 64'(tl_d_ready), 64'd0);
    check("reset_proto_err", 64'(proto_err_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    check("idle_d_ready", 64'(tl_d_ready), 64'd1);

    do_txn(3'd4, 3'd0, 4'd2, 32'h10, 4'h0, 32'h0, 0, 1'b0, 2, 32'hDEADBEEF);
    do_txn(3'd1, 3'd0, 4'd2, 32'h8, 4'b0101, 32'h12345678, 1, 1'b0, 2, 32'hFFFFFFFF);
    rdy_mode = 1;
    do_txn(3'd4, 3'd0, 4'd4, 32'h20, 4'h0, 32'h0, 0, 1'b0, 1, 32'h0);
    rdy_mode = 0;
    do_txn(3'd0, 3'd0, 4'd3, 32'h0, 4'h0, 32'h55, 0, 1'b0, 0, 32'h0);
    do_txn(3'd4, 3'd0, 4'd1, 32'h3, 4'h0, 32'h0, 0, 1'b0, 0, 32'h0);
    do_txn(3'd4, 3'd0, 4'd2, 32'h30, 4'h0, 32'h0, 5, 1'b1, 0, 32'h0);

    // Reset in the middle of a burst with an unconsumed beat buffered.
    rdy_mode = 2;
    @(negedge clk);
    issue_cmd(3'd4, 3'd0, 4'd4, 32'h40, 4'h0, 32'h0);
    a_phase(3'd4, 3'd0, 4'd4, 32'h40, 4'hF, 32'h0, 0);
    d_beat(3'd1, 32'hCAFE0001, 4'(SOURCE_ID), 1'b0, 1'b0, 1'b0);
    check("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
    in_d = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_reset_rsp_data", 64'(rsp_data), 64'd0);
    check("mid_reset_rsp_last", 64'(rsp_last), 64'd0);
    check("mid_reset_a_valid", 64'(tl_a_valid), 64'd0);
    check("mid_reset_a_addr", 64'(tl_a_address), 64'd0);
    check("mid_reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check("mid_reset_d_ready", 64'(tl_d_ready), 64'd0);
    check("mid_reset_proto_err", 64'(proto_err_o), 64'd0);
    exp_q.delete();
    exp_proto = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    do_txn(3'd4, 3'd0, 4'd3, 32'h80, 4'h0, 32'h0, 0, 1'b0, 1, 32'h0);

    for (int t = 0; t < 30; t++) begin
      op   = 3'($urandom_range(0, 5));
      sz   = (op == 3'd4) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 3));
      addr = ($urandom & 32'hFFFFFFC0) | 32'($urandom_range(0, 3));
      rdy_mode = $urandom_range(0, 1);
      do_txn(op, 3'($urandom_range(0, 7)), sz, addr, 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 3), 1'b0, 0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_ul_master_bridge.md
Name: tl_ul_master_bridge

Overview:
- Single-outstanding TileLink-UL/UH initiator that drives the A channel and consumes the D channel of slaves such as the on-chip SRAM.
- Converts a simple valid/ready command port (one command → one transaction) into one A-channel request.
- Returns each D-channel beat on a registered response port.
- Supports single-beat Get/PutFullData/PutPartialData/ArithmeticData/LogicalData and multi-beat Get bursts up to MAX_SIZE.

Parameters:
- TL_AW, 32, address width in bits.
- TL_RS, 4, source-ID width in bits.
- SOURCE_ID, 0, constant a_source driven on every request.
- MAX_SIZE, 6, largest legal log2 byte size for Get (6 = 64 B = 16 beats).

Ports:
- tlm_clock_i  in  1  clock.
- tlm_reset_ni  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_opcode  in  3  TL A opcode: 0 PutFull, 1 PutPartial, 2 Arith, 3 Logical, 4 Get.
- cmd_param  in  3  atomic param, passed through to a_param.
- cmd_size  in  4  log2 transfer bytes.
- cmd_address  in  TL_AW  byte address.
- cmd_mask  in  4  byte enables; PutPartial only.
- cmd_data  in  32  write/operand data.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  32  read data; 0 for AccessAck.
- rsp_error  out  1  d_denied | d_corrupt | illegal command.
- rsp_last  out  1  final beat of the transaction.
- tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address, tl_a_mask, tl_a_data, tl_a_corrupt  out  3/3/4/TL_RS/TL_AW/4/32/1  A channel.
- tl_a_valid  out  1.
- tl_a_ready  in  1.
- tl_d_opcode, tl_d_param, tl_d_size, tl_d_source, tl_d_denied, tl_d_data, tl_d_corrupt  in  3/2/4/TL_RS/1/32/1  D channel.
- tl_d_valid  in  1.
- tl_d_ready  out  1.
- proto_err_o  out  1  sticky flag: unexpected D beat.

Behaviour:
- Reset: async assert on tlm_reset_ni low. All outputs go to 0, state goes to IDLE, proto_err_o clears. Reset mid-transaction abandons it; no response is produced.
- FSM states: IDLE, A_REQ, D_WAIT, ERR_RSP.
- IDLE:
  - cmd_ready = 1 when rsp_valid = 0 or rsp_ready = 1.
  - On accept, legality is checked:
    - opcode ≤ 4;
    - size ≤ 2 for Put and atomics;
    - size ≤ MAX_SIZE for Get;
    - address aligned to 2^size (low min(size,2) bits zero for size ≤ 2; low 2 bits zero for size > 2).
  - Legal command: register all A fields and go to A_REQ; tl_a_valid rises the next cycle.
  - Illegal command: go to ERR_RSP; no bus traffic.
- A_REQ:
  - tl_a_valid = 1.
  - All A fields stay stable until tl_a_ready.
  - tl_a_source = SOURCE_ID; tl_a_corrupt = 0.
  - On handshake: tl_a_valid drops in the same edge, beat counter loads 2^(size-2)-1 for size > 2 and 0 otherwise, state goes to D_WAIT.
- tl_a_mask:
  - size 0: one-hot at address[1:0].
  - size 1: 4'b0011 << address[1:0].
  - size ≥ 2: 4'hF.
  - PutPartial: cmd_mask & derived mask.
  - Get uses the derived mask.
- D_WAIT:
  - tl_d_ready = ~rsp_valid | rsp_ready, so at most one beat is buffered in the response register.
  - On a D handshake with tl_d_source == SOURCE_ID:
    - rsp_data = tl_d_data for AccessAckData, 0 otherwise;
    - rsp_error = tl_d_denied | tl_d_corrupt;
    - rsp_last = (counter == 0);
    - rsp_valid = 1 next cycle.
  - Counter decrements per beat. At counter == 0 the state returns to IDLE.
  - D beat with mismatched source, or any D beat outside D_WAIT: tl_d_ready stays 1 for it (drain), proto_err_o sets, no rsp.
- ERR_RSP: one cycle. Sets rsp_valid = 1, rsp_error = 1, rsp_last = 1, rsp_data = 0, then returns to IDLE.
- rsp_valid: held until rsp_ready, then cleared unless a new beat loads in the same cycle, giving full throughput back to back.
- Latency: cmd accept → tl_a_valid is 1 cycle. D beat → rsp_valid is 1 cycle.
- tl_a_valid and tl_d_ready: never combinationally dependent on tl_a_ready or tl_d_valid.

Decomposition:
- Package tl_pkg:
  - A opcodes: Get = 4, PutFullData = 0, PutPartialData = 1, ArithmeticData = 2, LogicalData = 3.
  - D opcodes: AccessAck = 0, AccessAckData = 1.
  - FSM state enum.
- Sub-module tl_mask_gen: combinational (size, address[1:0]) → derived mask. Reusable by slaves for checking.

Test Plan:
- Get size 2 at 0x10, slave returns AccessAckData 0xDEADBEEF → a_mask 4'hF, one rsp: data 0xDEADBEEF, rsp_last = 1, rsp_error = 0.
- PutPartial size 2 at 0x8, cmd_mask 4'b0101 → a_mask 4'b0101, AccessAck gives rsp_data 0, rsp_last = 1.
- Get size 4 at 0x20, slave sends 4 beats 1,2,3,4 while rsp_ready toggles 1/0 → 4 rsp beats in order, rsp_last only on the 4th, tl_d_ready low whenever the buffer is full and not draining.
- Put size 3, and Get size 1 at 0x3 (misaligned) → no tl_a_valid, rsp_error = 1 and rsp_last = 1 within 2 cycles.
- tl_a_ready held low 5 cycles → A fields stable throughout; D beat with source SOURCE_ID+1 → proto_err_o = 1, no rsp.
- Reset asserted while in D_WAIT → all outputs 0 immediately, FSM IDLE; next Get completes normally.
